// File: rtl/and_result_checker.sv
// Scores AND-stage results (c == a & b) over a fixed-length vector campaign.
// Optional idle watchdog in RUN: define AND_CHK_TIMEOUT_EN.
module and_result_checker #(
    parameter int WIDTH       = 1,
    parameter int CNT_W       = 8,
    parameter int NUM_VECTORS = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic             done,
    output logic             pass,
    output logic             err,
    output logic             timeout,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_xor
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] vec_idx;
    logic             accept;
    logic             clear;
    logic             last;
    logic             idle_hit;
    logic [WIDTH-1:0] exp_c;
    logic [WIDTH-1:0] diff;
    logic             miss;

    assign exp_c  = in_a & in_b;
    assign diff   = exp_c ^ in_c;
    assign miss   = |diff;
    assign accept = in_valid & in_ready;
    assign last   = accept && (vec_idx == LAST_IDX);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        clear     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    clear     = 1'b1;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                if (last || idle_hit) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    clear     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign done = (state == DONE);
    assign pass = done & ~err & ~timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters saturate rather than wrap so overflow cannot mask failures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_idx       <= '0;
            match_cnt     <= '0;
            mismatch_cnt  <= '0;
            err           <= 1'b0;
            first_err_idx <= '0;
            first_err_xor <= '0;
        end else if (clear) begin
            vec_idx       <= '0;
            match_cnt     <= '0;
            mismatch_cnt  <= '0;
            err           <= 1'b0;
            first_err_idx <= '0;
            first_err_xor <= '0;
        end else if (accept) begin
            if (vec_idx != CNT_MAX) vec_idx <= vec_idx + 1'b1;
            if (miss) begin
                if (mismatch_cnt != CNT_MAX) begin
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                end
                err <= 1'b1;
                if (!err) begin
                    first_err_idx <= vec_idx;
                    first_err_xor <= diff;
                end
            end else if (match_cnt != CNT_MAX) begin
                match_cnt <= match_cnt + 1'b1;
            end
        end
    end

`ifdef AND_CHK_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_cnt;

    // An accept on the would-be expiry cycle wins and rearms the watchdog.
    assign idle_hit = (state == RUN) && !accept &&
                      (idle_cnt == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else if (clear) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else if (state == RUN) begin
            if (accept) begin
                idle_cnt <= '0;
            end else if (idle_hit) begin
                idle_cnt <= '0;
                timeout  <= 1'b1;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
`else
    logic [31:0] unused_timeout_cfg;

    assign unused_timeout_cfg = TIMEOUT;
    assign idle_hit           = 1'b0;
    assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_and_result_checker.sv
// Directed bench for and_result_checker: truth table, fault capture,
// gaps, async reset, restart and the optional idle watchdog.
module tb_and_result_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [0:0] in_a = '0;
    logic [0:0] in_b = '0;
    logic [0:0] in_c = '0;
    logic       done;
    logic       pass;
    logic       err;
    logic       timeout;
    logic [7:0] match_cnt;
    logic [7:0] mismatch_cnt;
    logic [7:0] first_err_idx;
    logic [0:0] first_err_xor;

    int passed = 0;
    int total  = 0;

    and_result_checker #(
        .WIDTH(1), .CNT_W(8), .NUM_VECTORS(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .done(done), .pass(pass), .err(err), .timeout(timeout),
        .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt),
        .first_err_idx(first_err_idx), .first_err_xor(first_err_xor)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic a, input logic b, input logic c);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_c = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_tmo"}, timeout, 0);
        chk({tag, "_rdy"}, in_ready, 0);
        chk({tag, "_mcnt"}, match_cnt, 0);
        chk({tag, "_xcnt"}, mismatch_cnt, 0);
        chk({tag, "_fidx"}, first_err_idx, 0);
        chk({tag, "_fxor"}, first_err_xor, 0);
    endtask

    initial begin
        // Reset state
        #2;
        chk_zero("rst");
        tick();
        rst_n = 1'b1;
        tick();
        chk_zero("idle");

        // in_valid in IDLE is ignored
        send(1, 1, 1);
        send(1, 1, 0);
        chk("idle_valid_mcnt", match_cnt, 0);
        chk("idle_valid_xcnt", mismatch_cnt, 0);

        // Truth table campaign
        pulse_start();
        chk("tt_rdy", in_ready, 1);
        chk("tt_done0", done, 0);
        send(0, 0, 0);
        chk("tt_mcnt1", match_cnt, 1);
        send(1, 0, 0);
        send(0, 1, 0);
        chk("tt_done3", done, 0);
        send(1, 1, 1);
        chk("tt_done", done, 1);
        chk("tt_pass", pass, 1);
        chk("tt_mcnt", match_cnt, 4);
        chk("tt_xcnt", mismatch_cnt, 0);
        chk("tt_err", err, 0);
        chk("tt_rdy_done", in_ready, 0);
        send(1, 1, 0);
        chk("done_hold_mcnt", match_cnt, 4);
        chk("done_hold_xcnt", mismatch_cnt, 0);
        chk("done_hold", done, 1);

        // Fault campaign, started from DONE
        pulse_start();
        chk("f_done_drop", done, 0);
        chk("f_clr_mcnt", match_cnt, 0);
        send(0, 0, 0);
        send(1, 0, 0);
        send(0, 1, 1);
        chk("f_err_early", err, 1);
        send(1, 1, 1);
        chk("f_done", done, 1);
        chk("f_pass", pass, 0);
        chk("f_mcnt", match_cnt, 3);
        chk("f_xcnt", mismatch_cnt, 1);
        chk("f_err", err, 1);
        chk("f_fidx", first_err_idx, 2);
        chk("f_fxor", first_err_xor, 1);

        // Restart from DONE clears capture, then clean run
        pulse_start();
        chk("rs_err", err, 0);
        chk("rs_fidx", first_err_idx, 0);
        chk("rs_fxor", first_err_xor, 0);
        chk("rs_xcnt", mismatch_cnt, 0);
        send(0, 0, 0);
        send(1, 0, 0);
        send(0, 1, 0);
        send(1, 1, 1);
        chk("rs_pass", pass, 1);
        chk("rs_mcnt", match_cnt, 4);

        // Gaps: valid 1,0,0,1,0,1,1 with a start pulse mid-RUN
        pulse_start();
        send(0, 0, 0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        send(1, 0, 0);
        chk("gap_mcnt2", match_cnt, 2);
        chk("gap_rdy", in_ready, 1);
        tick();
        send(0, 1, 0);
        chk("gap_done3", done, 0);
        send(1, 1, 1);
        chk("gap_done", done, 1);
        chk("gap_mcnt", match_cnt, 4);
        chk("gap_pass", pass, 1);

        // Reset mid-campaign acts without a clock edge
        pulse_start();
        send(0, 1, 1);
        send(1, 1, 1);
        chk("mid_mcnt", match_cnt, 1);
        chk("mid_xcnt", mismatch_cnt, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("arst");
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_idle_rdy", in_ready, 0);
        pulse_start();
        send(1, 1, 1);
        chk("post_rst_mcnt", match_cnt, 1);
        chk("post_rst_err", err, 0);
        send(0, 0, 0);
        send(0, 0, 0);
        send(1, 0, 0);
        chk("post_rst_done", done, 1);
        chk("post_rst_mcnt4", match_cnt, 4);

        // Idle watchdog
        pulse_start();
        send(1, 1, 1);
`ifdef AND_CHK_TIMEOUT_EN
        repeat (15) tick();
        chk("wd_done15", done, 0);
        tick();
        chk("wd_done", done, 1);
        chk("wd_tmo", timeout, 1);
        chk("wd_pass", pass, 0);
        chk("wd_mcnt", match_cnt, 1);
`else
        repeat (100) tick();
        chk("nowd_done", done, 0);
        chk("nowd_rdy", in_ready, 1);
        chk("nowd_tmo", timeout, 0);
        chk("nowd_mcnt", match_cnt, 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/and_result_checker.md
Name: and_result_checker

Overview:
- Downstream consumer of the 2-input AND stage output: samples operand pairs (a, b) together with the stage result c, recomputes the expected AND and scores each vector.
- Runs a fixed-length vector campaign per start pulse; reports match/mismatch counts, sticky error and first-failure capture.
- Sits after the AND stage in self-checking benches and information-flow test designs. Synthesizable, single clock domain.

Parameters:
- WIDTH, 1, bit width of a, b, c (bitwise AND).
- CNT_W, 8, width of vector index and match/mismatch counters.
- NUM_VECTORS, 4, vectors accepted per campaign (1 .. 2^CNT_W-1).
- TIMEOUT, 16, idle cycles in RUN before abort (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a campaign from IDLE or DONE.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  checker can accept a sample.
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- in_c  in  WIDTH  AND-stage result under check.
- done  out  1  campaign finished (level, held in DONE).
- pass  out  1  done and mismatch_cnt==0 and no timeout.
- err  out  1  sticky: at least one mismatch this campaign.
- timeout  out  1  campaign aborted by idle watchdog.
- match_cnt  out  CNT_W  vectors with in_c == in_a & in_b.
- mismatch_cnt  out  CNT_W  vectors with in_c != in_a & in_b.
- first_err_idx  out  CNT_W  index (0-based) of the first mismatching vector.
- first_err_xor  out  WIDTH  (in_a & in_b) ^ in_c of the first mismatch.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including counters, the index and the capture registers. Reset takes effect immediately, including mid-campaign. Registers are released on the first clk edge after rst_n rises.
- FSM states: IDLE, RUN, DONE (2-bit encoding).
- IDLE: in_ready=0. When start=1, go to RUN next cycle. The same edge clears the counters, vec_idx, err, timeout and the capture registers.
- RUN: in_ready=1 combinationally from the state. Accept occurs on the edge where in_valid & in_ready = 1.
  - On accept: exp = in_a & in_b.
  - Match: match_cnt+1. Mismatch: mismatch_cnt+1 and err<=1.
  - If this is the first mismatch (err was 0), latch first_err_idx<=vec_idx and first_err_xor<=exp^in_c.
  - vec_idx+1 on every accept.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Transition RUN->DONE on the edge of the accept where vec_idx == NUM_VECTORS-1. done=1 from the next cycle; zero extra latency.
- start asserted in RUN is ignored. in_valid in IDLE or DONE is ignored; no accept occurs.
- DONE: in_ready=0, done=1, pass = ~err & ~timeout. All result outputs hold. When start=1, go to RUN with the same clears as IDLE (done and pass drop next cycle).
- Results update exactly one cycle after the accepting edge (registered outputs). done and pass are registered or decoded from the state register only; no combinational input-to-output paths except in_ready from the state.

Optional Feature:
- Macro: AND_CHK_TIMEOUT_EN.
- Defined:
  - An idle counter counts RUN cycles with no accept and resets to 0 on each accept and on entry to RUN.
  - When it reaches TIMEOUT, the FSM goes RUN->DONE and sets timeout<=1; pass=0.
  - If an accept happens on the same cycle the counter would reach TIMEOUT, the accept wins and the counter resets.
- Undefined: no watchdog logic; timeout is tied to 0; RUN waits indefinitely.

Test Plan:
- Truth table: start, then vectors (a,b,c) = (0,0,0),(1,0,0),(0,1,0),(1,1,1), valid every cycle. Required: done=1 one cycle after the 4th accept, pass=1, match_cnt=4, mismatch_cnt=0, err=0.
- Fault injection: same campaign, but vector 2 drives c=1 (a=0,b=1). Required: mismatch_cnt=1, match_cnt=3, err=1, first_err_idx=2, first_err_xor=1, pass=0.
- Gaps and ignored inputs: in_valid toggled 1,0,0,1,0,1,1, plus in_valid=1 while in IDLE and a start pulse mid-RUN. Required: only valid cycles in RUN are counted; done after exactly 4 accepts; the mid-RUN start has no effect.
- Reset mid-operation: drop rst_n after 2 accepts. Required: all outputs read 0 asynchronously and the state is IDLE. A new start runs a clean campaign with counts starting from 0.
- Restart from DONE: after the fault campaign, pulse start and run a clean truth table. Required: err, first_err_idx and first_err_xor are cleared, then pass=1, match_cnt=4.
- With AND_CHK_TIMEOUT_EN and TIMEOUT=16: start, one accept, then in_valid=0. Required: done=1, timeout=1, pass=0 after 16 idle cycles, match_cnt=1. Without the macro, the same stimulus leaves the checker in RUN with done=0 after 100 cycles.
